pc_gen: RTL and testbench

Parametrised fetch-PC generator that supersedes the fixed 4-byte-increment PC register in the IF stage. It holds the current fetch address and presents it to instruction fetch under a valid/ready handshake. It arbitrates any number of prioritised redirect sources (EX branch resolution, exception/trap, …). It predicts next-PC from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, trained from EX.

---
 rtl/pc_gen_pkg.sv | 23 ++
 rtl/pc_gen_btb_table.sv | 84 ++++++++
 rtl/pc_gen.sv | 81 ++++++++
 tb/tb_pc_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-PC generator: BTB counter encodings,
// width helpers and the codebase-wide Branch/NoStop constants.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Branch marks a resolved-taken direction; NoStop is the always-valid fetch level.
    localparam logic Branch = 1'b1;
    localparam logic NoStop = 1'b1;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/pc_gen_btb_table.sv
// Direct-mapped branch target buffer: combinational lookup port and a
// synchronous training port with 2-bit saturating counters.
module btb_table
    import pc_gen_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int FETCH_BYTES = 4,
    parameter int BTB_ENTRIES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              lk_taken,
    output logic [ADDR_W-1:0] lk_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_taken
);

    localparam int OFF   = clog2(FETCH_BYTES);
    localparam int IDX_W = clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF;

    logic              valid_mem [BTB_ENTRIES];
    ctr_e              ctr_mem   [BTB_ENTRIES];
    logic [TAG_W-1:0]  tag_mem   [BTB_ENTRIES];
    logic [ADDR_W-1:0] tgt_mem   [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             lk_hit;
    logic             upd_hit;
    logic             upd_en;
    logic             unused_low_bits;

    assign lk_idx  = lk_pc[OFF +: IDX_W];
    assign lk_tag  = lk_pc[ADDR_W-1 -: TAG_W];
    assign upd_idx = upd_pc[OFF +: IDX_W];
    assign upd_tag = upd_pc[ADDR_W-1 -: TAG_W];
    assign unused_low_bits = ^{lk_pc[OFF-1:0], upd_pc[OFF-1:0]};

    assign lk_hit    = valid_mem[lk_idx] && (tag_mem[lk_idx] == lk_tag);
    assign lk_taken  = lk_hit && ctr_mem[lk_idx][1];
    assign lk_target = tgt_mem[lk_idx];

    assign upd_hit = valid_mem[upd_idx] && (tag_mem[upd_idx] == upd_tag);
    assign upd_en  = rdy && upd_valid;

    // Valid bits and counters are cleared on reset; a miss that resolves
    // not-taken leaves the entry untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_mem[i] <= 1'b0;
                ctr_mem[i]   <= SNT;
            end
        end else if (upd_en) begin
            if (upd_hit) begin
                if (upd_taken == Branch) begin
                    if (ctr_mem[upd_idx] != ST)
                        ctr_mem[upd_idx] <= ctr_e'(ctr_mem[upd_idx] + 2'd1);
                end else if (ctr_mem[upd_idx] != SNT) begin
                    ctr_mem[upd_idx] <= ctr_e'(ctr_mem[upd_idx] - 2'd1);
                end
            end else if (upd_taken == Branch) begin
                valid_mem[upd_idx] <= 1'b1;
                ctr_mem[upd_idx]   <= WT;
            end
        end
    end

    // Tag and target are only meaningful behind a set valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        if (upd_en && upd_taken == Branch) begin
            tag_mem[upd_idx] <= upd_tag;
            tgt_mem[upd_idx] <= upd_target;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator: PC register, prioritised redirect selection and
// BTB-predicted sequential advance under a valid/ready handshake.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter int                FETCH_BYTES  = 4,
    parameter int                BTB_ENTRIES  = 16,
    parameter int                NUM_REDIRECT = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rdy,
    input  logic [NUM_REDIRECT-1:0]        redir_valid,
    input  logic [NUM_REDIRECT*ADDR_W-1:0] redir_addr,
    output logic                           pc_valid,
    output logic [ADDR_W-1:0]              pc,
    output logic                           pc_pred_taken,
    output logic [ADDR_W-1:0]              pc_pred_target,
    input  logic                           pc_ready,
    input  logic                           upd_valid,
    input  logic [ADDR_W-1:0]              upd_pc,
    input  logic [ADDR_W-1:0]              upd_target,
    input  logic                           upd_taken
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(FETCH_BYTES - 1);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(FETCH_BYTES);

    logic              btb_taken;
    logic [ADDR_W-1:0] btb_target;
    logic              redir_any;
    logic [ADDR_W-1:0] redir_sel;

    btb_table #(
        .ADDR_W      (ADDR_W),
        .FETCH_BYTES (FETCH_BYTES),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .lk_pc      (pc),
        .lk_taken   (btb_taken),
        .lk_target  (btb_target),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_target (upd_target),
        .upd_taken  (upd_taken)
    );

    assign pc_valid       = NoStop;
    assign pc_pred_taken  = btb_taken;
    assign pc_pred_target = btb_taken ? btb_target : pc + STEP;

    // Scan from the highest channel down so the lowest asserted index wins.
    always_comb begin
        redir_any = 1'b0;
        redir_sel = '0;
        for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                redir_any = 1'b1;
                redir_sel = redir_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // A redirect overrides the handshake; a PC accepted in that same cycle is flushed downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC & ALIGN_MASK;
        end else if (rdy) begin
            if (redir_any)
                pc <= redir_sel & ALIGN_MASK;
            else if (pc_valid && pc_ready)
                pc <= pc_pred_target;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios with literal expectations
// plus a randomized phase checked every cycle against a behavioural model.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic [1:0]  redir_valid = '0;
    logic [63:0] redir_addr = '0;
    logic        pc_valid;
    logic [31:0] pc;
    logic        pc_pred_taken;
    logic [31:0] pc_pred_target;
    logic        pc_ready = 1'b0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_pc = '0;
    logic [31:0] upd_target = '0;
    logic        upd_taken = 1'b0;

    int checks = 0;
    int failures = 0;
    bit checkEn = 1'b0;

    typedef struct {
        bit          v;
        logic [31:0] tag;
        logic [31:0] tgt;
        int          ctr;
    } ent_t;

    ent_t        mb[16];
    logic [31:0] m_pc;

    pc_gen dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .redir_valid    (redir_valid),
        .redir_addr     (redir_addr),
        .pc_valid       (pc_valid),
        .pc             (pc),
        .pc_pred_taken  (pc_pred_taken),
        .pc_pred_target (pc_pred_target),
        .pc_ready       (pc_ready),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .upd_taken      (upd_taken)
    );

    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_pc = 32'h0;
        foreach (mb[i]) begin
            mb[i].v   = 1'b0;
            mb[i].tag = '0;
            mb[i].tgt = '0;
            mb[i].ctr = 0;
        end
    endtask

    // Entry index is word address mod 16, tag is everything above the 64-byte span.
    task automatic modelLookup(input logic [31:0] p, output bit tk, output logic [31:0] tg);
        int idx;
        idx = int'((p / 4) % 16);
        tk = mb[idx].v && (mb[idx].tag == p / 64) && (mb[idx].ctr >= 2);
        tg = tk ? mb[idx].tgt : p + 32'd4;
    endtask

    task automatic trainModel();
        int idx;
        logic [31:0] tg;
        idx = int'((upd_pc / 4) % 16);
        tg  = upd_pc / 64;
        if (mb[idx].v && mb[idx].tag == tg) begin
            if (upd_taken) begin
                if (mb[idx].ctr < 3) mb[idx].ctr++;
                mb[idx].tgt = upd_target;
            end else if (mb[idx].ctr > 0) begin
                mb[idx].ctr--;
            end
        end else if (upd_taken) begin
            mb[idx].v   = 1'b1;
            mb[idx].tag = tg;
            mb[idx].tgt = upd_target;
            mb[idx].ctr = 2;
        end
    endtask

    task automatic step();
        bit          tk;
        bit          live;
        logic [31:0] tg;
        logic [31:0] npc;
        live = rst && rdy;
        modelLookup(m_pc, tk, tg);
        npc = m_pc;
        if (redir_valid[0])      npc = redir_addr[31:0] & ~32'd3;
        else if (redir_valid[1]) npc = redir_addr[63:32] & ~32'd3;
        else if (pc_ready)       npc = tg;
        @(posedge clk);
        if (live) begin
            m_pc = npc;
            if (upd_valid) trainModel();
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit r, input logic [1:0] rv,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input bit rd, input bit uv, input logic [31:0] up,
                                 input logic [31:0] ut, input bit utk);
        rdy         = r;
        redir_valid = rv;
        redir_addr  = {a1, a0};
        pc_ready    = rd;
        upd_valid   = uv;
        upd_pc      = up;
        upd_target  = ut;
        upd_taken   = utk;
        step();
    endtask

    task automatic checkOutput();
        bit          tk;
        logic [31:0] tg;
        modelLookup(m_pc, tk, tg);
        compare("pc", pc, m_pc);
        compare("pc_valid", 32'(pc_valid), 32'd1);
        compare("pred_taken", 32'(pc_pred_taken), 32'(tk));
        compare("pred_target", pc_pred_target, tg);
    endtask

    always @(negedge clk) begin
        if (checkEn) checkOutput();
    end

    function automatic logic [31:0] randAddr();
        return 32'($urandom_range(0, 3) * 1024 + $urandom_range(0, 255) * 4);
    endfunction

    initial begin
        modelReset();
        rdy = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        checkEn = 1'b1;
        compare("reset_pc", pc, 32'h0);
        compare("reset_taken", 32'(pc_pred_taken), 32'd0);
        compare("reset_target", pc_pred_target, 32'h4);

        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1, 2'b00, 0, 0, 1, 0, 0, 0, 0);
            compare("seq_pc", pc, 32'(k * 4));
            compare("seq_taken", 32'(pc_pred_taken), 32'd0);
        end

        applyStimulus(1, 2'b01, 32'h10, 0, 0, 0, 0, 0, 0);
        compare("redir_to_10", pc, 32'h10);
        applyStimulus(1, 2'b11, 32'h100, 32'h200, 1, 0, 0, 0, 0);
        compare("redir_priority", pc, 32'h100);
        applyStimulus(1, 2'b10, 0, 32'h203, 1, 0, 0, 0, 0);
        compare("redir_align", pc, 32'h200);

        applyStimulus(1, 2'b01, 32'h20, 0, 0, 1, 32'h20, 32'h80, 1);
        compare("train_taken", 32'(pc_pred_taken), 32'd1);
        compare("train_target", pc_pred_target, 32'h80);
        applyStimulus(1, 2'b00, 0, 0, 1, 0, 0, 0, 0);
        compare("follow_pred", pc, 32'h80);
        repeat (2) applyStimulus(1, 2'b00, 0, 0, 0, 1, 32'h20, 32'h80, 0);
        applyStimulus(1, 2'b01, 32'h20, 0, 0, 0, 0, 0, 0);
        compare("untrained_taken", 32'(pc_pred_taken), 32'd0);
        applyStimulus(1, 2'b00, 0, 0, 1, 0, 0, 0, 0);
        compare("untrained_seq", pc, 32'h24);

        applyStimulus(1, 2'b00, 0, 0, 0, 1, 32'h20, 32'h80, 1);
        applyStimulus(1, 2'b00, 0, 0, 0, 1, 32'h60, 32'hC0, 1);
        applyStimulus(1, 2'b01, 32'h20, 0, 0, 0, 0, 0, 0);
        compare("alias_miss", 32'(pc_pred_taken), 32'd0);
        compare("alias_target", pc_pred_target, 32'h24);
        applyStimulus(1, 2'b01, 32'h60, 0, 0, 0, 0, 0, 0);
        compare("alias_new_hit", pc_pred_target, 32'hC0);

        applyStimulus(1, 2'b01, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 2'b00, 0, 0, 1, 0, 0, 0, 0);
        compare("wrap_pc", pc, 32'h0);
        applyStimulus(0, 2'b01, 32'h500, 0, 1, 1, 32'h0, 32'h300, 1);
        compare("frozen_pc", pc, 32'h0);
        applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        compare("frozen_btb", 32'(pc_pred_taken), 32'd0);

        applyStimulus(1, 2'b00, 0, 0, 0, 1, 32'h40, 32'h90, 1);
        applyStimulus(1, 2'b01, 32'h40, 0, 0, 0, 0, 0, 0);
        compare("pre_reset_taken", 32'(pc_pred_taken), 32'd1);
        #2 rst = 1'b0;
        #1;
        compare("async_reset_pc", pc, 32'h0);
        compare("async_reset_taken", 32'(pc_pred_taken), 32'd0);
        modelReset();
        applyStimulus(1, 2'b00, 0, 0, 1, 0, 0, 0, 0);
        rst = 1'b1;
        applyStimulus(1, 2'b01, 32'h40, 0, 0, 0, 0, 0, 0);
        compare("post_reset_40", 32'(pc_pred_taken), 32'd0);
        applyStimulus(1, 2'b01, 32'h60, 0, 0, 0, 0, 0, 0);
        compare("post_reset_60", 32'(pc_pred_taken), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            logic [1:0] rv;
            rv[0] = ($urandom_range(0, 7) == 0);
            rv[1] = ($urandom_range(0, 7) == 0);
            applyStimulus($urandom_range(0, 9) != 0, rv,
                          randAddr() | 32'($urandom_range(0, 3)),
                          randAddr() | 32'($urandom_range(0, 3)),
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 1) == 1,
                          randAddr(), randAddr(),
                          $urandom_range(0, 2) != 0);
        end

        checkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
